// File: rtl/fitbit_pkg.sv
// Shared constants and helpers for the pedometer display path.
// Mode encodings, anode constants and BCD digit extraction.
package fitbit_pkg;

  localparam int DIGIT_W = 4;
  localparam logic [3:0] AN_OFF = 4'b1111;

  typedef enum logic [1:0] {
    MODE_STEPS = 2'b00,
    MODE_DIST  = 2'b01,
    MODE_RATE  = 2'b10,
    MODE_HIGH  = 2'b11
  } mode_e;

  function automatic logic [DIGIT_W-1:0] bcd_at(
    input logic [15:0] w,
    input logic [1:0]  k
  );
    return w[{k, 2'b00} +: DIGIT_W];
  endfunction

endpackage

// File: rtl/fitbit_display_scheduler_tick_divider.sv
// Free-running modulo-DIV counter with enable and clear.
// tick is high during the last count of each period while enabled.
module tick_divider #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic RESET,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt;

  assign tick = en && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (RESET) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/fitbit_display_scheduler.sv
// Rotates four BCD metrics onto a 4-digit multiplexed display
// with per-frame snapshots, leading-zero blanking and dp control.
module fitbit_display_scheduler
  import fitbit_pkg::*;
#(
  parameter int SCAN_DIV = 100000,
  parameter int MODE_DIV = 200000000
) (
  input  logic        clk,
  input  logic        RESET,
  input  logic        START,
  input  logic        HOLD,
  input  logic        SI,
  input  logic [15:0] step_bcd,
  input  logic [15:0] dist_bcd,
  input  logic [15:0] rate_bcd,
  input  logic [15:0] high_bcd,
  output logic [1:0]  mode,
  output logic        mode_adv,
  output logic [3:0]  an,
  output logic [3:0]  digit,
  output logic        dp
);

  logic scan_tick;
  logic mode_tick;

  tick_divider #(.DIV(SCAN_DIV)) u_scan (
    .clk   (clk),
    .RESET (RESET),
    .en    (1'b1),
    .clr   (1'b0),
    .tick  (scan_tick)
  );

  tick_divider #(.DIV(MODE_DIV)) u_mode (
    .clk   (clk),
    .RESET (RESET),
    .en    (START & ~HOLD),
    .clr   (~START),
    .tick  (mode_tick)
  );

  mode_e mode_q, mode_d;
  logic  adv_q;

  always_ff @(posedge clk) begin
    if (RESET) begin
      mode_q <= MODE_STEPS;
      adv_q  <= 1'b0;
    end else begin
      mode_q <= mode_d;
      adv_q  <= mode_tick;
    end
  end

  always_comb begin
    mode_d = mode_q;
    if (mode_tick) begin
      unique case (mode_q)
        MODE_STEPS: mode_d = MODE_DIST;
        MODE_DIST:  mode_d = MODE_RATE;
        MODE_RATE:  mode_d = MODE_HIGH;
        MODE_HIGH:  mode_d = MODE_STEPS;
        default:    mode_d = MODE_STEPS;
      endcase
    end
  end

  logic [15:0] word_sel;

  always_comb begin
    word_sel = step_bcd;
    unique case (mode_q)
      MODE_STEPS: word_sel = step_bcd;
      MODE_DIST:  word_sel = dist_bcd;
      MODE_RATE:  word_sel = rate_bcd;
      MODE_HIGH:  word_sel = high_bcd;
      default:    word_sel = step_bcd;
    endcase
  end

  // Mode travels with the shadow word so one frame is self-consistent.
  logic [1:0]  slot_q;
  logic [15:0] sh_word;
  logic        sh_si;
  mode_e       sh_mode;
  logic        frame_end;

  assign frame_end = scan_tick && (slot_q == 2'd3);

  always_ff @(posedge clk) begin
    if (RESET) begin
      slot_q  <= 2'd0;
      sh_word <= '0;
      sh_si   <= 1'b0;
      sh_mode <= MODE_STEPS;
    end else begin
      if (scan_tick) begin
        slot_q <= slot_q + 2'd1;
      end
      if (frame_end) begin
        sh_word <= word_sel;
        sh_si   <= SI;
        sh_mode <= mode_q;
      end
    end
  end

  logic [15:0]        above;
  logic               keep;
  logic               blank;
  logic [3:0]         an_d;
  logic [DIGIT_W-1:0] digit_d;
  logic               dp_d;

  always_comb begin
    above   = sh_word >> {slot_q, 2'b00};
    keep    = (sh_mode == MODE_DIST) && (slot_q == 2'd1);
    blank   = (slot_q != 2'd0) && (above == 16'h0) && !keep;
    an_d    = ~(4'b0001 << slot_q);
    digit_d = bcd_at(sh_word, slot_q);
    dp_d    = 1'b1;
    if (keep) begin
      dp_d = 1'b0;
    end
    if ((sh_mode == MODE_STEPS) && sh_si && (slot_q == 2'd0)) begin
      dp_d = 1'b0;
    end
    if (blank) begin
      an_d    = AN_OFF;
      digit_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (RESET) begin
      an    <= AN_OFF;
      digit <= '0;
      dp    <= 1'b1;
    end else begin
      an    <= an_d;
      digit <= digit_d;
      dp    <= dp_d;
    end
  end

  assign mode     = mode_q;
  assign mode_adv = adv_q;

endmodule

// File: tb/tb_fitbit_display_scheduler.sv
// Directed checks of mode rotation, scanning, blanking and snapshots
// with SCAN_DIV=4 and MODE_DIV=64.
module tb_fitbit_display_scheduler;

  logic        clk = 1'b0;
  logic        RESET = 1'b0;
  logic        START = 1'b0;
  logic        HOLD = 1'b0;
  logic        SI = 1'b0;
  logic [15:0] step_bcd = '0;
  logic [15:0] dist_bcd = '0;
  logic [15:0] rate_bcd = '0;
  logic [15:0] high_bcd = '0;
  logic [1:0]  mode;
  logic        mode_adv;
  logic [3:0]  an;
  logic [3:0]  digit;
  logic        dp;

  int n_cmp = 0;
  int n_err = 0;
  int t = 0;

  fitbit_display_scheduler #(
    .SCAN_DIV(4),
    .MODE_DIV(64)
  ) dut (
    .clk      (clk),
    .RESET    (RESET),
    .START    (START),
    .HOLD     (HOLD),
    .SI       (SI),
    .step_bcd (step_bcd),
    .dist_bcd (dist_bcd),
    .rate_bcd (rate_bcd),
    .high_bcd (high_bcd),
    .mode     (mode),
    .mode_adv (mode_adv),
    .an       (an),
    .digit    (digit),
    .dp       (dp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [15:0] obs,
                     input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s @t=%0d: observed %h expected %h",
             tag, t, obs, exp);
    end
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    @(posedge clk);
    #1;
    RESET = 1'b0;
    t = 0;
  endtask

  task automatic run_to(input int target);
    while (t < target) begin
      @(posedge clk);
      #1;
      t++;
    end
  endtask

  task automatic chk_disp(input string tag,
                          input logic [3:0] e_an,
                          input logic [3:0] e_dg,
                          input logic e_dp);
    chk({tag, ".an"}, 16'(an), 16'(e_an));
    chk({tag, ".digit"}, 16'(digit), 16'(e_dg));
    chk({tag, ".dp"}, 16'(dp), 16'(e_dp));
  endtask

  initial begin
    step_bcd = 16'h0042;
    do_reset();
    chk("rst.mode", 16'(mode), 16'd0);
    chk("rst.adv", 16'(mode_adv), 16'd0);
    chk_disp("rst", 4'b1111, 4'd0, 1'b1);

    run_to(1);
    chk_disp("zero.s0", 4'b1110, 4'd0, 1'b1);
    run_to(5);
    chk_disp("zero.s1", 4'b1111, 4'd0, 1'b1);

    run_to(17);
    chk_disp("s42.s0", 4'b1110, 4'd2, 1'b1);
    run_to(21);
    chk_disp("s42.s1", 4'b1101, 4'd4, 1'b1);
    step_bcd = 16'h0137;
    run_to(25);
    chk_disp("s42.s2", 4'b1111, 4'd0, 1'b1);
    run_to(29);
    chk_disp("s42.s3", 4'b1111, 4'd0, 1'b1);
    run_to(33);
    chk_disp("s137.s0", 4'b1110, 4'd7, 1'b1);
    run_to(37);
    chk_disp("s137.s1", 4'b1101, 4'd3, 1'b1);
    run_to(41);
    chk_disp("s137.s2", 4'b1011, 4'd1, 1'b1);
    run_to(45);
    chk_disp("s137.s3", 4'b1111, 4'd0, 1'b1);

    SI = 1'b1;
    step_bcd = 16'h9999;
    run_to(49);
    chk_disp("ovf.s0", 4'b1110, 4'd9, 1'b0);
    run_to(53);
    chk_disp("ovf.s1", 4'b1101, 4'd9, 1'b1);
    run_to(57);
    chk_disp("ovf.s2", 4'b1011, 4'd9, 1'b1);
    run_to(61);
    chk_disp("ovf.s3", 4'b0111, 4'd9, 1'b1);
    chk("idle.mode", 16'(mode), 16'd0);
    run_to(70);
    chk("idle.mode2", 16'(mode), 16'd0);
    chk("idle.adv", 16'(mode_adv), 16'd0);

    SI = 1'b0;
    step_bcd = 16'h0042;
    dist_bcd = 16'h0005;
    rate_bcd = 16'h0000;
    high_bcd = 16'h1234;
    do_reset();
    START = 1'b1;

    run_to(63);
    chk("rot.63.mode", 16'(mode), 16'd0);
    chk("rot.63.adv", 16'(mode_adv), 16'd0);
    run_to(64);
    chk("rot.64.mode", 16'(mode), 16'd1);
    chk("rot.64.adv", 16'(mode_adv), 16'd1);
    run_to(65);
    chk("rot.65.adv", 16'(mode_adv), 16'd0);
    chk_disp("wrapsame.s0", 4'b1110, 4'd2, 1'b1);

    run_to(81);
    chk_disp("dist.s0", 4'b1110, 4'd5, 1'b1);
    run_to(85);
    chk_disp("dist.s1", 4'b1101, 4'd0, 1'b0);
    run_to(89);
    chk_disp("dist.s2", 4'b1111, 4'd0, 1'b1);
    run_to(93);
    chk_disp("dist.s3", 4'b1111, 4'd0, 1'b1);

    run_to(127);
    chk("rot.127.adv", 16'(mode_adv), 16'd0);
    run_to(128);
    chk("rot.128.mode", 16'(mode), 16'd2);
    chk("rot.128.adv", 16'(mode_adv), 16'd1);
    run_to(145);
    chk_disp("rate.s0", 4'b1110, 4'd0, 1'b1);
    run_to(149);
    chk_disp("rate.s1", 4'b1111, 4'd0, 1'b1);

    run_to(192);
    chk("rot.192.mode", 16'(mode), 16'd3);
    chk("rot.192.adv", 16'(mode_adv), 16'd1);
    run_to(209);
    chk_disp("high.s0", 4'b1110, 4'd4, 1'b1);
    run_to(221);
    chk_disp("high.s3", 4'b0111, 4'd1, 1'b1);

    run_to(256);
    chk("rot.256.mode", 16'(mode), 16'd0);
    chk("rot.256.adv", 16'(mode_adv), 16'd1);

    run_to(276);
    HOLD = 1'b1;
    for (int i = 0; i < 100; i++) begin
      run_to(t + 1);
      chk("hold.adv", 16'(mode_adv), 16'd0);
    end
    chk("hold.mode", 16'(mode), 16'd0);
    HOLD = 1'b0;
    run_to(419);
    chk("rel.419.adv", 16'(mode_adv), 16'd0);
    chk("rel.419.mode", 16'(mode), 16'd0);
    run_to(420);
    chk("rel.420.adv", 16'(mode_adv), 16'd1);
    chk("rel.420.mode", 16'(mode), 16'd1);

    run_to(426);
    do_reset();
    chk("mid.mode", 16'(mode), 16'd0);
    chk("mid.adv", 16'(mode_adv), 16'd0);
    chk_disp("mid", 4'b1111, 4'd0, 1'b1);
    run_to(1);
    chk_disp("mid.s0", 4'b1110, 4'd0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fitbit_display_scheduler.md
# fitbit_display_scheduler

Sequences the pedometer's four metric displays (steps, distance, 32+ step/s seconds, high-activity seconds) onto the shared 4-digit seven-segment display. It owns the mode rotation timer, the digit-scan multiplexer, leading-zero blanking and decimal-point control. It sits between the step-counter datapath, which supplies four BCD metric words, and the board's anode/segment decoder.

## Interface
Parameters:
- SCAN_DIV, 100000: clk cycles per digit slot; must be ≥2.
- MODE_DIV, 200000000: clk cycles per display mode (2 s at 100 MHz); must be ≥2.

Ports:
- clk  in  1  system clock.
- RESET  in  1  reset; one clock, synchronous and active-high.
- START  in  1  level; 1 enables mode rotation.
- HOLD  in  1  level; 1 freezes the current mode.
- SI  in  1  step-count overflow flag from the datapath.
- step_bcd  in  16  steps, 4 BCD digits, [3:0] = least-significant digit (LSD).
- dist_bcd  in  16  distance, 4 BCD digits, in tenths of a mile.
- rate_bcd  in  16  seconds at 32+ steps/s, 4 BCD digits.
- high_bcd  in  16  high-activity seconds, 4 BCD digits.
- mode  out  2  current display mode.
- mode_adv  out  1  one-cycle pulse when mode changes.
- an  out  4  digit anodes, active-low; an[0] = LSD.
- digit  out  4  BCD value for the lit digit.
- dp  out  1  decimal point, active-low.

## Operation
- Mode FSM: STEPS(00) → DIST(01) → RATE(10) → HIGH(11) → STEPS.
  - mode_cnt counts 0..MODE_DIV-1 while START=1 and HOLD=0.
  - At MODE_DIV-1: mode advances, mode_cnt returns to 0, mode_adv=1 for that cycle.
- START=0: mode_cnt forced to 0; mode holds its value; no mode_adv.
- HOLD=1 with START=1: mode_cnt frozen and mode held. On HOLD release, counting resumes from the frozen value.
- Scan: scan_cnt counts 0..SCAN_DIV-1 unconditionally. At wrap, slot (2 bits) increments 3→0.
- Snapshot: when slot wraps 3→0, the 16-bit word selected by the current mode and SI are latched into shadow registers.
  - All four digits of one frame come from one snapshot, so frames never tear.
- Digit select: digit = shadow[4*slot+3 : 4*slot]; an = ~(1<<slot).
- Blanking (STEPS, RATE, HIGH):
  - A digit in slot k>0 is blanked (an=4'b1111, digit=0) if it and all higher digits are 0.
  - Slot 0 is never blanked.
- DIST: no blanking for slots 0–1 (leading "0.x" shown); dp=0 in slot 1; slots 2–3 are blanked by the same rule.
- STEPS with shadowed SI=1: dp=0 in slot 0 (overflow indicator).
- In every other case, dp=1.
- Reset values: mode=00, mode_adv=0, an=4'b1111, digit=0, dp=1; all counters, slot and shadow = 0.

## Timing
- All outputs are registered.
- an/digit/dp reflect slot and shadow one cycle after a slot change.
- Mode-change latency to display: mode updates on the cycle after mode_cnt=MODE_DIV-1. The new word appears at the next 3→0 slot wrap, i.e. ≤ 4·SCAN_DIV+1 cycles.
- mode_adv is asserted in the same cycle that mode shows its new value.
- RESET has priority over all events. Reset mid-frame blanks an on the next edge, and scanning restarts at slot 0 with a zero snapshot.
- Mode wrap and slot wrap on the same cycle: the snapshot uses the pre-advance mode. The new mode is displayed one frame later.
- START falling on the same cycle as a mode wrap: the mode does not advance.
- Input words are sampled only at a snapshot edge; changes at any other time are ignored until the next frame.

## Structure
- Package fitbit_pkg:
  - mode constants MODE_STEPS/DIST/RATE/HIGH (2-bit);
  - AN_OFF = 4'b1111;
  - BCD digit width = 4.
- Sub-module tick_divider (parameter DIV; inputs clk, RESET, en, clr; output tick):
  - instanced once for the scan tick (en=1, clr=0);
  - instanced once for the mode tick (en=START&~HOLD, clr=~START).
- The top level holds the mode FSM, the slot counter, the snapshot and the blanking/dp logic.

## Test plan
(all with SCAN_DIV=4, MODE_DIV=64)
- Reset release with START=0 → mode=00, mode_adv=0 indefinitely; an cycles 1110/1101/1011/0111 with blanking applied; slot period 4 cycles.
- START=1, HOLD=0 → mode_adv pulses every 64 cycles; mode sequence 00,01,10,11,00.
- step_bcd=16'h0042 in STEPS → slot0 digit=2, slot1 digit=4, slots 2–3 an=1111; dp=1.
- DIST, dist_bcd=16'h0005 → slot0=5, slot1=0 with dp=0, slots 2–3 blank.
- STEPS with SI=1, step_bcd=16'h9999 → all four digits 9; dp=0 only in slot 0.
- HOLD=1 for 100 cycles mid-interval → no mode_adv during HOLD; the next pulse arrives 64 minus the elapsed count cycles after release.
- RESET during slot 2 → next edge an=1111, dp=1, mode=00.
- step_bcd changed mid-frame → the displayed digits change only after the next slot-3→0 wrap.
